// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with false-start rejection,
// parity/framing/break/overrun detection and a one-entry valid/ready
// holding register in front of the packet parser.
module uart_rx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 104,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 framing_err_o,
  output logic                 break_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int FW = $clog2(SYNC_STAGES + 1);

  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [FW-1:0] FLUSHED   = FW'(SYNC_STAGES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE,
    S_WAIT_HIGH
  } state_t;

  // Synchroniser and start-edge qualification
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FW-1:0]          flush_q, flush_d;
  logic                   prev_q, prev_d;
  logic                   rx_s;
  logic                   flushed;
  logic                   fall;

  // Frame assembly
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_bit_q, par_bit_d;
  logic                   zero_q, zero_d;
  logic                   frm_seen_q, frm_seen_d;
  logic                   pending_q, pending_d;
  logic                   tick;
  logic                   par_ones;
  logic                   par_bad;

  // Output side
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d;
  logic                   brk_q, brk_d;
  logic                   ovr_q, ovr_d;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign flushed = (flush_q == FLUSHED);
  assign fall    = prev_q & ~rx_s;

  // Mid-bit sample strobe: half a bit after the start edge, then every full bit.
  assign tick = (state_q == S_START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);

  // Count of ones over data plus parity bit; odd mode wants it odd, even mode even.
  assign par_ones = ^{shift_q, par_bit_q};
  assign par_bad  = (PARITY == 1) ? ~par_ones :
                    (PARITY == 2) ?  par_ones : 1'b0;

  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign parity_err_o  = par_err_q;
  assign framing_err_o = frm_err_q;
  assign break_o       = brk_q;
  assign overrun_o     = ovr_q;
  assign busy_o        = (state_q != S_IDLE);

  // Edge history only tracks the line once the synchroniser holds real samples,
  // so a line already low when reset releases never looks like a start edge.
  always_comb begin
    flush_d = flushed ? flush_q : flush_q + 1'b1;
    prev_d  = flushed ? rx_s : 1'b0;
  end

  // Synchroniser chain, edge history and flush counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '1;
      flush_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
      flush_q <= flush_d;
      prev_q  <= prev_d;
    end
  end

  // Next-state logic: frame sequencing, outcome resolution and handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    zero_d     = zero_q;
    frm_seen_d = frm_seen_q;
    pending_d  = 1'b0;
    data_d     = data_q;
    valid_d    = valid_q & ~ready_i;
    par_err_d  = 1'b0;
    frm_err_d  = 1'b0;
    brk_d      = 1'b0;
    ovr_d      = 1'b0;

    if (state_q == S_START || state_q == S_DATA ||
        state_q == S_PARITY || state_q == S_STOP) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // An edge seen while DONE was resolving is honoured one cycle late.
        if (fall || pending_q) begin
          state_d    = S_START;
          bit_d      = '0;
          zero_d     = 1'b1;
          frm_seen_d = 1'b0;
          par_bit_d  = 1'b0;
        end
      end

      S_START: begin
        if (tick) begin
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (rx_s) zero_d = 1'b0;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (tick) begin
          par_bit_d = rx_s;
          if (rx_s) zero_d = 1'b0;
          bit_d   = '0;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (tick) begin
          if (rx_s) zero_d = 1'b0;
          else      frm_seen_d = 1'b1;
          if (bit_q == STOP_LAST) begin
            state_d = S_DONE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        pending_d = fall;
        state_d   = S_IDLE;
        if (zero_q) begin
          brk_d   = 1'b1;
          state_d = S_WAIT_HIGH;
        end else if (frm_seen_q) begin
          frm_err_d = 1'b1;
          par_err_d = par_bad;
        end else if (par_bad) begin
          par_err_d = 1'b1;
        end else if (!valid_q || ready_i) begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end

      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, frame and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      zero_q     <= 1'b0;
      frm_seen_q <= 1'b0;
      pending_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      zero_q     <= zero_d;
      frm_seen_q <= frm_seen_d;
      pending_q  <= pending_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 and even-parity instances at 16 clk/bit.
module tb_uart_rx_param;

  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       ready_a = 1'b1;
  logic       ready_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       par_a, frm_a, brk_a, ovr_a, busy_a;
  logic       par_b, frm_b, brk_b, ovr_b, busy_b;

  int checks = 0;
  int errors = 0;

  // Monitor-owned event counters and captured words
  int         n_a = 0, n_b = 0;
  logic [7:0] words_a [0:63];
  logic [7:0] words_b [0:63];
  int         cnt_par_a = 0, cnt_frm_a = 0, cnt_brk_a = 0, cnt_ovr_a = 0, cnt_busy_a = 0;
  int         cnt_par_b = 0, cnt_frm_b = 0, cnt_brk_b = 0, cnt_ovr_b = 0;

  always #5 clk = ~clk;

  uart_rx_param #(
    .DATA_BITS(8), .CLKS_PER_BIT(BIT), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .rx_i(rx_a), .data_o(data_a), .valid_o(valid_a),
    .ready_i(ready_a), .parity_err_o(par_a), .framing_err_o(frm_a),
    .break_o(brk_a), .overrun_o(ovr_a), .busy_o(busy_a)
  );

  uart_rx_param #(
    .DATA_BITS(8), .CLKS_PER_BIT(BIT), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .rx_i(rx_b), .data_o(data_b), .valid_o(valid_b),
    .ready_i(ready_b), .parity_err_o(par_b), .framing_err_o(frm_b),
    .break_o(brk_b), .overrun_o(ovr_b), .busy_o(busy_b)
  );

  // Sample outputs on the falling edge; a word counts as delivered when valid & ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_a && ready_a) begin
        words_a[n_a[5:0]] <= data_a;
        n_a <= n_a + 1;
        $display("rx_a word 0x%02h", data_a);
      end
      if (valid_b && ready_b) begin
        words_b[n_b[5:0]] <= data_b;
        n_b <= n_b + 1;
        $display("rx_b word 0x%02h", data_b);
      end
      if (par_a)  cnt_par_a  <= cnt_par_a + 1;
      if (frm_a)  cnt_frm_a  <= cnt_frm_a + 1;
      if (brk_a)  cnt_brk_a  <= cnt_brk_a + 1;
      if (ovr_a)  cnt_ovr_a  <= cnt_ovr_a + 1;
      if (busy_a) cnt_busy_a <= cnt_busy_a + 1;
      if (par_b)  cnt_par_b  <= cnt_par_b + 1;
      if (frm_b)  cnt_frm_b  <= cnt_frm_b + 1;
      if (brk_b)  cnt_brk_b  <= cnt_brk_b + 1;
      if (ovr_b)  cnt_ovr_b  <= cnt_ovr_b + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold one line level for one bit time, starting on a falling edge.
  task automatic drive_bit(input bit to_b, input logic v);
    if (to_b) rx_b = v;
    else      rx_a = v;
    repeat (BIT) @(negedge clk);
  endtask

  // Start, 8 data LSB first, optional parity, one stop, two idle bits.
  task automatic send_frame(input bit to_b, input logic [7:0] d,
                            input bit with_par, input logic pbit);
    $display("tx_%s 0x%02h par=%0d/%0d", to_b ? "b" : "a", d, with_par, pbit);
    drive_bit(to_b, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(to_b, d[i]);
    if (with_par) drive_bit(to_b, pbit);
    drive_bit(to_b, 1'b1);
    drive_bit(to_b, 1'b1);
    drive_bit(to_b, 1'b1);
  endtask

  function automatic int errs_a();
    return cnt_par_a + cnt_frm_a + cnt_brk_a + cnt_ovr_a;
  endfunction

  initial begin
    logic [7:0] seq [0:5];
    int base, e0, b0;
    seq[0] = 8'hEC; seq[1] = 8'h00; seq[2] = 8'h06;
    seq[3] = 8'h00; seq[4] = 8'h48; seq[5] = 8'h69;

    // Reset state
    repeat (4) @(negedge clk);
    check("reset_valid", {31'd0, valid_a}, 32'd0);
    check("reset_data", {24'd0, data_a}, 32'd0);
    check("reset_busy", {31'd0, busy_a}, 32'd0);
    rst = 1'b0;
    repeat (BIT) @(negedge clk);

    // Packet header + payload, consumer always ready
    base = n_a;
    for (int k = 0; k < 6; k++) send_frame(1'b0, seq[k], 1'b0, 1'b0);
    check("pkt_count", n_a - base, 32'd6);
    for (int k = 0; k < 6; k++) check($sformatf("pkt_word%0d", k), {24'd0, words_a[base + k]}, {24'd0, seq[k]});
    check("pkt_errors", errs_a(), 32'd0);

    // Even parity: 0x48 has two ones, so parity bit 0 is good, 1 is bad
    send_frame(1'b1, 8'h48, 1'b1, 1'b0);
    check("par_good_count", n_b, 32'd1);
    check("par_good_word", {24'd0, words_b[0]}, 32'h48);
    check("par_good_no_err", cnt_par_b, 32'd0);
    send_frame(1'b1, 8'h48, 1'b1, 1'b1);
    check("par_bad_pulse", cnt_par_b, 32'd1);
    check("par_bad_no_word", n_b, 32'd1);
    check("par_bad_no_frm", cnt_frm_b, 32'd0);

    // Stalled consumer: first word held, second dropped with overrun
    ready_a = 1'b0;
    base = n_a;
    send_frame(1'b0, 8'h06, 1'b0, 1'b0);
    check("hold_valid", {31'd0, valid_a}, 32'd1);
    check("hold_data", {24'd0, data_a}, 32'h06);
    send_frame(1'b0, 8'h00, 1'b0, 1'b0);
    check("ovr_pulse", cnt_ovr_a, 32'd1);
    check("ovr_keep_data", {24'd0, data_a}, 32'h06);
    check("ovr_keep_valid", {31'd0, valid_a}, 32'd1);
    @(posedge clk); #1 ready_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pop_valid_low", {31'd0, valid_a}, 32'd0);
    check("pop_count", n_a - base, 32'd1);
    check("pop_word", {24'd0, words_a[base]}, 32'h06);

    // Short glitch is rejected as a false start
    base = n_a; e0 = errs_a(); b0 = cnt_busy_a;
    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("glitch_busy_seen", {31'd0, (cnt_busy_a != b0)}, 32'd1);
    check("glitch_idle", {31'd0, busy_a}, 32'd0);
    check("glitch_no_word", n_a - base, 32'd0);
    check("glitch_no_flag", errs_a() - e0, 32'd0);

    // Break: 12 bit times low, then a normal frame
    base = n_a; b0 = cnt_brk_a; e0 = cnt_frm_a;
    rx_a = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("brk_pulse", cnt_brk_a - b0, 32'd1);
    check("brk_no_frm", cnt_frm_a - e0, 32'd0);
    check("brk_no_word", n_a - base, 32'd0);
    send_frame(1'b0, 8'h69, 1'b0, 1'b0);
    check("post_brk_count", n_a - base, 32'd1);
    check("post_brk_word", {24'd0, words_a[base]}, 32'h69);

    // Reset during data bit 3 of 0xEC while a word is being held
    ready_a = 1'b0;
    send_frame(1'b0, 8'h06, 1'b0, 1'b0);
    check("pre_rst_valid", {31'd0, valid_a}, 32'd1);
    e0 = errs_a();
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    rx_a = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_valid", {31'd0, valid_a}, 32'd0);
    check("rst_data", {24'd0, data_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ready_a = 1'b1;
    repeat (BIT) @(negedge clk);
    check("rst_no_flag", errs_a() - e0, 32'd0);
    base = n_a;
    send_frame(1'b0, 8'h48, 1'b0, 1'b0);
    check("post_rst_count", n_a - base, 32'd1);
    check("post_rst_word", {24'd0, words_a[base]}, 32'h48);

    // Line already low at reset release must not start a frame
    rx_a = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    b0 = cnt_busy_a;
    repeat (3 * BIT) @(negedge clk);
    check("low_release_busy", cnt_busy_a - b0, 32'd0);
    rx_a = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    base = n_a;
    send_frame(1'b0, 8'hEC, 1'b0, 1'b0);
    check("low_release_word", {24'd0, words_a[base]}, 32'hEC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
